// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
// Contents: occupancy-state enum, MEM-stage widths, field offsets and packed
// payload views for the EX/MEM and MEM/WB bundles.
package pipe_pkg;

  // Entries held by a stage; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned OCC_W = 2;

  // MEM stage bundle widths
  localparam int unsigned MEM_CTRL_W = 2;
  localparam int unsigned MEM_DATA_W = 68;

  // Control field bit positions
  localparam int unsigned CTRL_MEM_R_EN_BIT = 0;
  localparam int unsigned CTRL_WB_EN_BIT    = 1;

  // Data field offsets and widths
  localparam int unsigned DEST_W          = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEST_LSB        = 0;
  localparam int unsigned MEM_RD_VAL_LSB  = DEST_LSB + DEST_W;
  localparam int unsigned ALU_RESULT_LSB  = MEM_RD_VAL_LSB + WORD_W;

  // Packed views matching the offsets above
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
  } mem_ctrl_t;

  typedef struct packed {
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_read_value;
    logic [DEST_W-1:0] dest;
  } mem_data_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle carrying a control field and a data payload.
// master: producer (drives valid/ctrl/data, samples ready).
// slave : consumer (samples valid/ctrl/data, drives ready).
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = MEM_CTRL_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// Single pipeline entry: valid flag, control field and payload.
// Ports: clk, rst_n (async active-low), load_i (capture ctrl_i/data_i and set
// valid), clr_i (drop valid and zero ctrl, payload held; wins over load_i),
// valid_o/ctrl_o/data_o (registered entry contents).
module pipe_slot #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 68
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Payload is never zeroed by clear so bubbles cost no data-path toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register with freeze, synchronous flush and an
// optional skid slot (SKID=1 registers the state term of in_ready).
// Ports: clk, rst (async active-low), freeze (hold everything), flush (kill
// held entries next cycle), in_if (upstream slave handshake), out_if
// (downstream master handshake; ctrl zeroed when not valid), occupancy
// (registered count of held entries).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = MEM_CTRL_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  pipe_skid_stage_if.slave  in_if,
  pipe_skid_stage_if.master out_if,
  output logic [OCC_W-1:0] occupancy
);

  pipe_state_e state_q, state_d;

  logic              in_ready, in_fire, out_valid, out_fire;
  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;
  logic              head_load, head_clr, head_from_skid;
  logic              skid_load, skid_clr;

  // A full skid slot is exactly PS_TWO, so this term comes straight from a flop.
  assign in_ready = rst & ~freeze & ~flush &
                    ((SKID != 0) ? ~skid_valid : (~head_valid | out_if.ready));
  assign in_fire  = in_if.valid & in_ready;

  assign out_valid = head_valid & ~freeze & ~flush;
  assign out_fire  = out_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.ctrl  = out_valid ? head_ctrl : '0;
  assign out_if.data  = head_data;
  assign occupancy    = OCC_W'(state_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PS_EMPTY;
    else      state_q <= state_d;
  end

  // Next state and slot controls; flush beats freeze beats transfers.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = PS_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!freeze) begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d   = PS_ONE;
            head_load = 1'b1;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with SKID=1; SKID=0 in_ready requires out_ready.
            state_d   = PS_TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d  = PS_EMPTY;
            head_clr = 1'b1;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            state_d        = PS_ONE;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // Head refills from skid when draining TWO, otherwise from upstream.
  assign head_ctrl_in = head_from_skid ? skid_ctrl : in_if.ctrl;
  assign head_data_in = head_from_skid ? skid_data : in_if.data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (head_load),
    .clr_i   (head_clr),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_valid),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .ctrl_i  (in_if.ctrl),
        .data_i  (in_if.data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
    end
  endgenerate

endmodule
